// File: rtl/bsg_dfi_cmd_pkg.sv
// Shared types for the closed-page DFI command sequencer: FSM states,
// DDR3 command pin encodings and the latched request record.
package bsg_dfi_cmd_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_ACT, S_WAIT_RCD, S_RW, S_WAIT_PRE, S_PRE, S_WAIT_RP, S_REF, S_WAIT_RFC
  } state_e;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_DESEL = 4'b1111;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_RD    = 4'b0101;
  localparam logic [3:0] CMD_WR    = 4'b0100;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_REF   = 4'b0001;

  typedef struct packed {
    logic        write;
    logic [2:0]  bank;
    logic [15:0] row;
    logic [9:0]  col;
  } dfi_req_s;

endpackage

// File: rtl/bsg_dfi_cmd_timer.sv
// Loadable down-counter that parks at zero; zero_o flags expiry.
module bsg_dfi_cmd_timer #(
  parameter int                     cnt_width_p = 12,
  parameter logic [cnt_width_p-1:0] rst_val_p   = '0
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   load_i,
  input  logic [cnt_width_p-1:0] load_val_i,
  output logic                   zero_o
);

  logic [cnt_width_p-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)             cnt_d = load_val_i;
    else if (cnt_q != '0)   cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) cnt_q <= rst_val_p;
    else          cnt_q <= cnt_d;

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/bsg_dfi_cmd_sequencer.sv
// Closed-page DDR3 sequencer: ACT -> RD/WR -> PRE per request, periodic REF,
// and DFI data enables generated at the write/read latencies.
module bsg_dfi_cmd_sequencer
  import bsg_dfi_cmd_pkg::*;
#(
  parameter int trcd_p         = 4,
  parameter int trp_p          = 4,
  parameter int tras_p         = 10,
  parameter int trtp_p         = 4,
  parameter int twr_p          = 6,
  parameter int trfc_p         = 32,
  parameter int trefi_p        = 1560,
  parameter int wl_p           = 2,
  parameter int rl_p           = 4,
  parameter int burst_cycles_p = 2,
  parameter int cnt_width_p    = 12
) (
  input  logic        dfi_clk_1x_i,
  input  logic        dfi_rst_n_i,
  input  logic        init_done_i,
  input  logic        req_v_i,
  input  logic        req_write_i,
  input  logic [2:0]  req_bank_i,
  input  logic [15:0] req_row_i,
  input  logic [9:0]  req_col_i,
  output logic        req_ready_o,
  output logic [2:0]  dfi_bank_o,
  output logic [15:0] dfi_address_o,
  output logic        dfi_cs_n_o,
  output logic        dfi_ras_n_o,
  output logic        dfi_cas_n_o,
  output logic        dfi_we_n_o,
  output logic        dfi_cke_o,
  output logic        dfi_wrdata_en_o,
  output logic        dfi_rddata_en_o,
  output logic        busy_o,
  output logic        refresh_overrun_o
);

  typedef logic [cnt_width_p-1:0] cnt_t;

  // Wait timers are loaded in the command cycle and exit on the cycle they read zero,
  // so a gap of N cycles between commands loads N-2 (tRFC counts its full wait instead).
  localparam cnt_t RCD_LD  = cnt_t'(trcd_p - 2);
  localparam cnt_t RAS_LD  = cnt_t'(tras_p - 2);
  localparam cnt_t RTP_LD  = cnt_t'(trtp_p - 2);
  localparam cnt_t WRP_LD  = cnt_t'(wl_p + burst_cycles_p + twr_p - 2);
  localparam cnt_t RP_LD   = cnt_t'(trp_p - 2);
  localparam cnt_t RFC_LD  = cnt_t'(trfc_p - 1);
  localparam cnt_t REFI_LD = cnt_t'(trefi_p - 1);
  localparam int   WSR_W   = wl_p + burst_cycles_p - 1;
  localparam int   RSR_W   = rl_p + burst_cycles_p - 1;

  state_e     state_q, state_d;
  dfi_req_s   req_q, req_d;
  logic       ref_pend_q, ref_pend_d;
  logic       ovr_q, ovr_d;
  logic       cke_q;
  logic [WSR_W-1:0] wr_sr_q;
  logic [RSR_W-1:0] rd_sr_q;

  logic       wait_ld, wait_zero, ras_zero, ref_zero, ref_due;
  cnt_t       wait_val;
  logic [3:0] cmd;

  bsg_dfi_cmd_timer #(.cnt_width_p(cnt_width_p), .rst_val_p('0)) u_wait_tmr (
    .clk_i(dfi_clk_1x_i), .rst_n_i(dfi_rst_n_i), .load_i(wait_ld),
    .load_val_i(wait_val), .zero_o(wait_zero));

  bsg_dfi_cmd_timer #(.cnt_width_p(cnt_width_p), .rst_val_p('0)) u_ras_tmr (
    .clk_i(dfi_clk_1x_i), .rst_n_i(dfi_rst_n_i), .load_i(state_q == S_ACT),
    .load_val_i(RAS_LD), .zero_o(ras_zero));

  bsg_dfi_cmd_timer #(.cnt_width_p(cnt_width_p), .rst_val_p(REFI_LD)) u_ref_tmr (
    .clk_i(dfi_clk_1x_i), .rst_n_i(dfi_rst_n_i), .load_i(ref_zero),
    .load_val_i(REFI_LD), .zero_o(ref_zero));

  assign req_ready_o = dfi_rst_n_i & init_done_i & ~ref_pend_q & (state_q == S_IDLE);
  // An expiry this cycle counts as pending so the refresh can follow without a bubble.
  assign ref_due     = init_done_i & (ref_pend_q | ref_zero);

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    wait_ld  = 1'b0;
    wait_val = '0;
    unique case (state_q)
      S_IDLE: begin
        if (init_done_i && ref_pend_q) state_d = S_REF;
        else if (req_v_i && req_ready_o) begin
          req_d   = '{write: req_write_i, bank: req_bank_i, row: req_row_i, col: req_col_i};
          state_d = S_ACT;
        end else if (ref_due) state_d = S_REF;
      end
      S_ACT:      begin wait_ld = 1'b1; wait_val = RCD_LD; state_d = S_WAIT_RCD; end
      S_WAIT_RCD: if (wait_zero) state_d = S_RW;
      S_RW: begin
        wait_ld  = 1'b1;
        wait_val = req_q.write ? WRP_LD : RTP_LD;
        state_d  = S_WAIT_PRE;
      end
      S_WAIT_PRE: if (wait_zero && ras_zero) state_d = S_PRE;
      S_PRE:      begin wait_ld = 1'b1; wait_val = RP_LD; state_d = S_WAIT_RP; end
      S_REF:      begin wait_ld = 1'b1; wait_val = RFC_LD; state_d = S_WAIT_RFC; end
      S_WAIT_RP, S_WAIT_RFC:
        if (wait_zero) state_d = ref_due ? S_REF : S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  assign ref_pend_d = (ref_pend_q & (state_q != S_REF)) | ref_zero;
  assign ovr_d      = ovr_q | (ref_zero & ref_pend_q);

  always_comb begin
    cmd           = CMD_DESEL;
    dfi_bank_o    = '0;
    dfi_address_o = '0;
    unique case (state_q)
      S_ACT: begin cmd = CMD_ACT; dfi_bank_o = req_q.bank; dfi_address_o = req_q.row; end
      S_RW: begin
        cmd           = req_q.write ? CMD_WR : CMD_RD;
        dfi_bank_o    = req_q.bank;
        dfi_address_o = {5'b0, 1'b0, req_q.col};
      end
      S_PRE: begin cmd = CMD_PRE; dfi_bank_o = req_q.bank; dfi_address_o = 16'h0400; end
      S_REF: cmd = CMD_REF;
      default: ;
    endcase
  end

  always_ff @(posedge dfi_clk_1x_i or negedge dfi_rst_n_i)
    if (!dfi_rst_n_i) begin
      state_q    <= S_IDLE;
      req_q      <= '0;
      ref_pend_q <= 1'b0;
      ovr_q      <= 1'b0;
      cke_q      <= 1'b0;
      wr_sr_q    <= '0;
      rd_sr_q    <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      ref_pend_q <= ref_pend_d;
      ovr_q      <= ovr_d;
      cke_q      <= 1'b1;
      wr_sr_q    <= {wr_sr_q[WSR_W-2:0], (state_q == S_RW) &  req_q.write};
      rd_sr_q    <= {rd_sr_q[RSR_W-2:0], (state_q == S_RW) & ~req_q.write};
    end

  // Bit k holds the command from k+1 cycles ago; the enable window is latency..latency+burst-1.
  assign dfi_wrdata_en_o = |wr_sr_q[WSR_W-1:wl_p-1];
  assign dfi_rddata_en_o = |rd_sr_q[RSR_W-1:rl_p-1];

  assign {dfi_cs_n_o, dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o} = cmd;
  assign dfi_cke_o         = cke_q;
  assign busy_o            = (state_q != S_IDLE);
  assign refresh_overrun_o = ovr_q;

endmodule

// File: tb/tb_bsg_dfi_cmd_sequencer.sv
// Bench for bsg_dfi_cmd_sequencer: a schedule-based model books each command and
// data-enable cycle when a request or refresh is granted; outputs are compared per cycle.
module tb_bsg_dfi_cmd_sequencer;

  localparam int TRCD = 4, TRP = 4, TRAS = 10, TRTP = 4, TWR = 6, TRFC = 32;
  localparam int TREFI = 100, WL = 2, RL = 4, BL = 2;
  localparam logic [3:0] C_DESEL = 4'hF, C_ACT = 4'h3, C_RD = 4'h5, C_WR = 4'h4;
  localparam logic [3:0] C_PRE = 4'h2, C_REF = 4'h1;

  logic clk = 1'b0, rst_n = 1'b0, init = 1'b0, req_v = 1'b0, req_w = 1'b0;
  logic [2:0]  req_b = '0;
  logic [15:0] req_r = '0;
  logic [9:0]  req_c = '0;
  logic        rdy, cs_n, ras_n, cas_n, we_n, cke, wr_en, rd_en, busy, ovr_o;
  logic [2:0]  bank;
  logic [15:0] addr;
  logic [3:0]  cmd_o;
  logic [28:0] obs, expv;

  bsg_dfi_cmd_sequencer #(.trefi_p(TREFI)) dut (
    .dfi_clk_1x_i(clk), .dfi_rst_n_i(rst_n), .init_done_i(init),
    .req_v_i(req_v), .req_write_i(req_w), .req_bank_i(req_b), .req_row_i(req_r),
    .req_col_i(req_c), .req_ready_o(rdy), .dfi_bank_o(bank), .dfi_address_o(addr),
    .dfi_cs_n_o(cs_n), .dfi_ras_n_o(ras_n), .dfi_cas_n_o(cas_n), .dfi_we_n_o(we_n),
    .dfi_cke_o(cke), .dfi_wrdata_en_o(wr_en), .dfi_rddata_en_o(rd_en),
    .busy_o(busy), .refresh_overrun_o(ovr_o));

  assign cmd_o = {cs_n, ras_n, cas_n, we_n};
  assign obs   = {cmd_o, bank, addr, wr_en, rd_en, rdy, busy, cke, ovr_o};

  always #5 clk = ~clk;

  int vectors = 0, errs = 0;

  // Model: cycle count since reset release, first cycle the sequencer is idle,
  // refresh pending/overrun flags and a ring of booked per-cycle outputs.
  int         cyc, idle_from;
  bit         pend, ovr;
  logic [3:0] m_cmd[128];
  logic [2:0] m_bank[128];
  logic [15:0] m_addr[128];
  bit         m_wr[128], m_rd[128];

  task automatic model_reset();
    for (int i = 0; i < 128; i++) begin
      m_cmd[i] = C_DESEL; m_bank[i] = '0; m_addr[i] = '0; m_wr[i] = 0; m_rd[i] = 0;
    end
    cyc = 0; idle_from = 0; pend = 0; ovr = 0;
  endtask

  task automatic model_eval();
    int s = cyc % 128;
    expv = {m_cmd[s], m_bank[s], m_addr[s], m_wr[s], m_rd[s],
            init && !pend && cyc >= idle_from, cyc < idle_from, cyc >= 1, ovr};
  endtask

  task automatic sched_ref(input int r);
    m_cmd[r % 128] = C_REF;
    idle_from = r + TRFC + 1;
  endtask

  task automatic sched_req(input int t);
    int w, p, lat;
    w   = t + 1 + TRCD;
    p   = w + (req_w ? WL + BL + TWR : TRTP);
    if (t + 1 + TRAS > p) p = t + 1 + TRAS;
    lat = req_w ? WL : RL;
    m_cmd[(t+1) % 128] = C_ACT;  m_bank[(t+1) % 128] = req_b; m_addr[(t+1) % 128] = req_r;
    m_cmd[w % 128] = req_w ? C_WR : C_RD;
    m_bank[w % 128] = req_b;     m_addr[w % 128] = {6'b0, req_c};
    m_cmd[p % 128] = C_PRE;      m_bank[p % 128] = req_b;   m_addr[p % 128] = 16'h0400;
    for (int i = 0; i < BL; i++)
      if (req_w) m_wr[(w + lat + i) % 128] = 1; else m_rd[(w + lat + i) % 128] = 1;
    idle_from = p + TRP;
  endtask

  task automatic model_advance();
    int s    = cyc % 128;
    bit fire = (cyc % TREFI) == TREFI - 1;
    bit ref_now = (m_cmd[s] == C_REF);
    if (init && cyc >= idle_from) begin
      if (pend)       sched_ref(cyc + 1);
      else if (req_v) sched_req(cyc);
      else if (fire)  sched_ref(cyc + 1);
    end else if (init && cyc == idle_from - 1 && (pend || fire)) sched_ref(cyc + 1);
    if (fire && pend) ovr = 1;
    pend = (pend && !ref_now) || fire;
    m_cmd[s] = C_DESEL; m_bank[s] = '0; m_addr[s] = '0; m_wr[s] = 0; m_rd[s] = 0;
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req_v = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    init = 1'b1; rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      vectors++;
      if (obs !== {C_DESEL, 25'd0}) begin
        errs++; $display("FAIL reset_state got %h exp %h", obs, {C_DESEL, 25'd0});
      end
    end
  endtask

  task automatic test_single_burst(input bit wr);
    int act_c = -1, rw_c = -1, pre_c = -1, en_c = -1, rdy_c = -1;
    logic [15:0] act_a = '0, rw_a = '0, pre_a = '0;
    do_reset(); init = 1'b1;
    repeat (24) begin
      req_v = (cyc == 0); req_w = wr; req_b = 3'd5; req_r = 16'hBEEF; req_c = 10'h155;
      #1 model_eval();
      vectors++;
      if (obs !== expv) begin errs++; $display("FAIL burst%0d c%0d got %h exp %h", wr, cyc, obs, expv); end
      if (cmd_o == C_ACT && act_c < 0) begin act_c = cyc; act_a = addr; end
      if ((cmd_o == C_RD || cmd_o == C_WR) && rw_c < 0) begin rw_c = cyc; rw_a = addr; end
      if (cmd_o == C_PRE && pre_c < 0) begin pre_c = cyc; pre_a = addr; end
      if ((wr ? wr_en : rd_en) && en_c < 0) en_c = cyc;
      if (cyc > 0 && rdy && rdy_c < 0) rdy_c = cyc;
      model_advance(); @(negedge clk);
    end
    vectors++;
    if (act_c !== 1 || act_a !== 16'hBEEF) begin
      errs++; $display("FAIL act_time got c%0d/%h exp c1/beef", act_c, act_a);
    end
    vectors++;
    if (rw_c !== 5 || rw_a !== 16'h0155) begin
      errs++; $display("FAIL rw_time got c%0d/%h exp c5/0155", rw_c, rw_a);
    end
    vectors++;
    if (pre_c !== (wr ? 15 : 11) || pre_a !== 16'h0400) begin
      errs++; $display("FAIL pre_time got c%0d/%h exp c%0d/0400", pre_c, pre_a, wr ? 15 : 11);
    end
    vectors++;
    if (en_c !== (wr ? 7 : 9)) begin errs++; $display("FAIL data_en got c%0d exp c%0d", en_c, wr ? 7 : 9); end
    vectors++;
    if (rdy_c !== (wr ? 19 : 15)) begin errs++; $display("FAIL ready_back got c%0d exp c%0d", rdy_c, wr ? 19 : 15); end
  endtask

  task automatic test_refresh_idle();
    int ref1 = -1, ref2 = -1;
    logic [3:0] rdy_pts = '0;
    do_reset(); init = 1'b1;
    repeat (206) begin
      req_v = 1'b0;
      #1 model_eval();
      vectors++;
      if (obs !== expv) begin errs++; $display("FAIL ref_idle c%0d got %h exp %h", cyc, obs, expv); end
      if (cmd_o == C_REF) begin if (ref1 < 0) ref1 = cyc; else if (ref2 < 0) ref2 = cyc; end
      if (cyc == 99)  rdy_pts[3] = rdy;
      if (cyc == 100) rdy_pts[2] = rdy;
      if (cyc == 132) rdy_pts[1] = rdy;
      if (cyc == 133) rdy_pts[0] = rdy;
      model_advance(); @(negedge clk);
    end
    vectors++;
    if (ref1 !== 100 || ref2 !== 200) begin
      errs++; $display("FAIL ref_times got c%0d,c%0d exp c100,c200", ref1, ref2);
    end
    vectors++;
    if (rdy_pts !== 4'b1001) begin errs++; $display("FAIL ref_ready got %b exp 1001", rdy_pts); end
  endtask

  task automatic test_refresh_defer();
    int ref1 = -1;
    do_reset(); init = 1'b1;
    repeat (130) begin
      req_v = (cyc == 98); req_w = 1'b0; req_b = 3'd2; req_r = 16'h1234; req_c = 10'h3;
      #1 model_eval();
      vectors++;
      if (obs !== expv) begin errs++; $display("FAIL ref_defer c%0d got %h exp %h", cyc, obs, expv); end
      if (cmd_o == C_REF && ref1 < 0) ref1 = cyc;
      model_advance(); @(negedge clk);
    end
    vectors++;
    if (ref1 !== 113 || ovr_o !== 1'b0) begin
      errs++; $display("FAIL ref_deferred got c%0d ovr %b exp c113 ovr 0", ref1, ovr_o);
    end
  endtask

  task automatic test_overrun();
    logic [1:0] ov_pts = '0;
    do_reset(); init = 1'b0;
    repeat (245) begin
      req_v = 1'b0;
      init  = (cyc >= 201);
      #1 model_eval();
      vectors++;
      if (obs !== expv) begin errs++; $display("FAIL overrun c%0d got %h exp %h", cyc, obs, expv); end
      if (cyc == 199) ov_pts[1] = ovr_o;
      if (cyc == 200) ov_pts[0] = ovr_o;
      model_advance(); @(negedge clk);
    end
    vectors++;
    if (ov_pts !== 2'b01 || ovr_o !== 1'b1) begin
      errs++; $display("FAIL overrun_set got %b/%b exp 01/1", ov_pts, ovr_o);
    end
    do_reset(); #1;
    vectors++;
    if (ovr_o !== 1'b0) begin errs++; $display("FAIL overrun_clear got %b exp 0", ovr_o); end
  endtask

  task automatic test_reset_midop();
    do_reset(); init = 1'b1;
    repeat (6) begin
      req_v = (cyc == 0); req_w = 1'b1; req_b = 3'd7; req_r = 16'h00AA; req_c = 10'h2A;
      #1 model_eval();
      vectors++;
      if (obs !== expv) begin errs++; $display("FAIL midop_pre c%0d got %h exp %h", cyc, obs, expv); end
      model_advance(); @(negedge clk);
    end
    rst_n = 1'b0;
    repeat (2) begin
      #1;
      vectors++;
      if (obs !== {C_DESEL, 25'd0}) begin
        errs++; $display("FAIL midop_reset got %h exp %h", obs, {C_DESEL, 25'd0});
      end
      @(negedge clk);
    end
    rst_n = 1'b1; model_reset();
    repeat (20) begin
      req_v = (cyc == 0); req_w = 1'b0; req_b = 3'd1; req_r = 16'h4321; req_c = 10'h99;
      #1 model_eval();
      vectors++;
      if (obs !== expv) begin errs++; $display("FAIL midop_after c%0d got %h exp %h", cyc, obs, expv); end
      model_advance(); @(negedge clk);
    end
  endtask

  task automatic test_random();
    do_reset();
    repeat (1500) begin
      req_v = 1'($urandom_range(0, 1));
      req_w = 1'($urandom_range(0, 1));
      req_b = 3'($urandom);
      req_r = 16'($urandom);
      req_c = 10'($urandom);
      init  = ($urandom_range(0, 99) < 94);
      #1 model_eval();
      vectors++;
      if (obs !== expv) begin errs++; $display("FAIL random c%0d got %h exp %h", cyc, obs, expv); end
      model_advance(); @(negedge clk);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_burst(1'b0);
    test_single_burst(1'b1);
    test_refresh_idle();
    test_refresh_defer();
    test_overrun();
    test_reset_midop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
